// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, a 2-entry skid buffer,
// separate stall (hold) and flush (bubble) controls, and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned        CTRL_W      = 16,
  parameter int unsigned        DATA_W      = 128,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int unsigned        CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] w_main_ctrl_nxt;
  logic [DATA_W-1:0] w_main_data_nxt;
  logic [CTRL_W-1:0] w_skid_ctrl_nxt;
  logic [DATA_W-1:0] w_skid_data_nxt;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_acc;
  logic              w_deq;

  // Handshake: in_ready never depends on out_ready, so no ready chain ripples upstream.
  assign in_ready  = (r_state != S_TWO) & ~stall & ~flush;
  assign out_valid = (r_state != S_EMPTY);
  assign w_acc     = in_valid & in_ready;
  assign w_deq     = out_valid & out_ready & ~stall;

  assign out_ctrl   = out_valid ? r_main_ctrl : CTRL_BUBBLE;
  assign out_data   = out_valid ? r_main_data : '0;
  assign occupancy  = 2'(r_state);
  assign bubble_cnt = r_bubble_cnt;

  // Next-state and storage update; flush overrides everything but reset.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_ctrl_nxt = r_main_ctrl;
    w_main_data_nxt = r_main_data;
    w_skid_ctrl_nxt = r_skid_ctrl;
    w_skid_data_nxt = r_skid_data;
    if (flush) begin
      w_state_nxt = S_EMPTY;
    end else if (!stall) begin
      unique case (r_state)
        S_EMPTY: begin
          if (w_acc) begin
            w_state_nxt     = S_ONE;
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end
        end
        S_ONE: begin
          if (w_acc && w_deq) begin
            w_main_ctrl_nxt = in_ctrl;
            w_main_data_nxt = in_data;
          end else if (w_acc) begin
            w_state_nxt     = S_TWO;
            w_skid_ctrl_nxt = in_ctrl;
            w_skid_data_nxt = in_data;
          end else if (w_deq) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_TWO: begin
          if (w_deq) begin
            w_state_nxt     = S_ONE;
            w_main_ctrl_nxt = r_skid_ctrl;
            w_main_data_nxt = r_skid_data;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_EMPTY;
      r_main_ctrl <= CTRL_BUBBLE;
      r_main_data <= '0;
      r_skid_ctrl <= CTRL_BUBBLE;
      r_skid_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_main_ctrl <= w_main_ctrl_nxt;
      r_main_data <= w_main_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
    end
  end

  // Counts cycles the stage presents a bubble downstream; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (!out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, reset/saturation sequences,
// and a cycle-level queue model checking every cycle during random traffic.
module tb_pipe_stage_reg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 128;
  localparam logic [CTRL_W-1:0] BUB = 16'hB0B0;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       bubble_cnt;

  logic              s_in_ready;
  logic              s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_occupancy;
  logic [2:0]        s_bubble_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_BUBBLE(BUB), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue model: entries held by the stage, updated at each clock edge.
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_bub  = '0;
  logic [2:0]  m_bub3 = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    if (mon_en) begin
      chk("mon_in_ready", DATA_W'(in_ready), DATA_W'((q.size() != 2) && !stall && !flush));
      chk("mon_out_valid", DATA_W'(out_valid), DATA_W'(q.size() != 0));
      chk("mon_occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
      chk("mon_out_ctrl", DATA_W'(out_ctrl), DATA_W'((q.size() != 0) ? q[0].c : BUB));
      chk("mon_out_data", out_data, (q.size() != 0) ? q[0].d : '0);
      chk("mon_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bub));
      chk("mon_bubble_cnt3", DATA_W'(s_bubble_cnt), DATA_W'(m_bub3));
    end
    if (!rst) begin
      q.delete();
      m_bub  = '0;
      m_bub3 = '0;
      mon_en = 1'b1;
    end else begin
      if (q.size() == 0) begin
        if (m_bub != 16'hFFFF) m_bub++;
        if (m_bub3 != 3'd7) m_bub3++;
      end
      if (flush) begin
        q.delete();
      end else if (!stall) begin
        bit do_acc;
        do_acc = in_valid && (q.size() != 2);
        if ((q.size() != 0) && out_ready) void'(q.pop_front());
        if (do_acc) q.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  typedef struct {
    logic              iv;
    logic [CTRL_W-1:0] c;
    logic              ordy;
    logic              st;
    logic              fl;
    logic [CTRL_W-1:0] e_ctrl;
    logic [1:0]        e_occ;
    logic              e_ir;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(input logic iv, input logic [CTRL_W-1:0] c, input logic ordy,
                              input logic st, input logic fl, input logic [CTRL_W-1:0] e_ctrl,
                              input logic [1:0] e_occ, input logic e_ir);
    vec_t v;
    v.iv = iv; v.c = c; v.ordy = ordy; v.st = st; v.fl = fl;
    v.e_ctrl = e_ctrl; v.e_occ = e_occ; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [CTRL_W-1:0] c, input logic ordy,
                       input logic st, input logic fl);
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = {8{c}};
    out_ready = ordy;
    stall     = st;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             iv  ctrl    ordy st fl  exp_ctrl occ ir
    tbl[0]  = mk(1, 16'h1,  1, 0, 0, 16'h1,  2'd1, 1);   // streaming
    tbl[1]  = mk(1, 16'h2,  1, 0, 0, 16'h2,  2'd1, 1);
    tbl[2]  = mk(1, 16'h3,  1, 0, 0, 16'h3,  2'd1, 1);
    tbl[3]  = mk(1, 16'h4,  1, 0, 0, 16'h4,  2'd1, 1);
    tbl[4]  = mk(0, 16'h0,  1, 0, 0, BUB,    2'd0, 1);
    tbl[5]  = mk(1, 16'hA,  0, 0, 0, 16'hA,  2'd1, 1);   // backpressure
    tbl[6]  = mk(1, 16'hB,  0, 0, 0, 16'hA,  2'd2, 0);
    tbl[7]  = mk(1, 16'hC,  0, 0, 0, 16'hA,  2'd2, 0);
    tbl[8]  = mk(1, 16'hC,  1, 0, 0, 16'hB,  2'd1, 1);
    tbl[9]  = mk(1, 16'hC,  1, 0, 0, 16'hC,  2'd1, 1);
    tbl[10] = mk(0, 16'h0,  1, 0, 0, BUB,    2'd0, 1);
    tbl[11] = mk(1, 16'h11, 0, 0, 0, 16'h11, 2'd1, 1);   // stall while full
    tbl[12] = mk(1, 16'h12, 0, 0, 0, 16'h11, 2'd2, 0);
    tbl[13] = mk(1, 16'h13, 1, 1, 0, 16'h11, 2'd2, 0);
    tbl[14] = mk(1, 16'h13, 1, 1, 0, 16'h11, 2'd2, 0);
    tbl[15] = mk(1, 16'h13, 1, 1, 0, 16'h11, 2'd2, 0);
    tbl[16] = mk(1, 16'h13, 1, 0, 0, 16'h12, 2'd1, 1);
    tbl[17] = mk(1, 16'h13, 1, 0, 0, 16'h13, 2'd1, 1);
    tbl[18] = mk(0, 16'h0,  1, 0, 0, BUB,    2'd0, 1);
    tbl[19] = mk(1, 16'h21, 0, 0, 0, 16'h21, 2'd1, 1);   // flush during stall
    tbl[20] = mk(1, 16'h22, 0, 0, 0, 16'h21, 2'd2, 0);
    tbl[21] = mk(1, 16'h23, 0, 1, 1, BUB,    2'd0, 0);
    tbl[22] = mk(0, 16'h0,  0, 0, 0, BUB,    2'd0, 1);

    rst = 1'b0;
    drive(0, '0, 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    chk("reset_occupancy", DATA_W'(occupancy), DATA_W'(0));
    chk("reset_out_valid", DATA_W'(out_valid), DATA_W'(0));
    chk("reset_in_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("reset_out_ctrl", DATA_W'(out_ctrl), DATA_W'(BUB));
    chk("reset_out_data", out_data, '0);
    chk("reset_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(0));

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].iv, tbl[i].c, tbl[i].ordy, tbl[i].st, tbl[i].fl);
      step();
      chk($sformatf("vec%0d_out_ctrl", i), DATA_W'(out_ctrl), DATA_W'(tbl[i].e_ctrl));
      chk($sformatf("vec%0d_out_data", i), out_data,
          (tbl[i].e_occ != 2'd0) ? {8{tbl[i].e_ctrl}} : '0);
      chk($sformatf("vec%0d_occupancy", i), DATA_W'(occupancy), DATA_W'(tbl[i].e_occ));
      chk($sformatf("vec%0d_out_valid", i), DATA_W'(out_valid), DATA_W'(tbl[i].e_occ != 2'd0));
      chk($sformatf("vec%0d_in_ready", i), DATA_W'(in_ready), DATA_W'(tbl[i].e_ir));
    end

    // Reset mid-stream with both entries held.
    drive(1, 16'h31, 0, 0, 0);
    step();
    drive(1, 16'h32, 0, 0, 0);
    step();
    chk("prereset_occupancy", DATA_W'(occupancy), DATA_W'(2));
    rst = 1'b0;
    drive(1, 16'h33, 1, 0, 0);
    step();
    rst = 1'b1;
    drive(0, '0, 0, 0, 0);
    chk("midreset_occupancy", DATA_W'(occupancy), DATA_W'(0));
    chk("midreset_in_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("midreset_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(0));
    chk("midreset_out_ctrl", DATA_W'(out_ctrl), DATA_W'(BUB));
    for (int i = 0; i < 5; i++) step();
    chk("idle5_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(5));
    for (int i = 0; i < 5; i++) step();
    chk("idle10_bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(10));
    chk("idle10_bubble_cnt_sat", DATA_W'(s_bubble_cnt), DATA_W'(7));

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_ctrl   = 16'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 3) != 0);
      stall     = 1'($urandom_range(0, 5) == 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      step();
    end
    drive(0, '0, 1, 0, 0);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
